// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA raster timing: sync, blank, frame marker and a pixel request
// that runs REQ_LEAD clocks ahead of display so a fixed-latency generator lines up.
module vga_timing_gen_param #(
   parameter int H_SYNC   = 96,
   parameter int H_BACK   = 48,
   parameter int H_ACTIVE = 640,
   parameter int H_FRONT  = 16,
   parameter int V_SYNC   = 2,
   parameter int V_BACK   = 33,
   parameter int V_ACTIVE = 480,
   parameter int V_FRONT  = 10,
   parameter int HS_POL   = 0,
   parameter int VS_POL   = 0,
   parameter int COLOR_W  = 8,
   parameter int CNT_W    = 12,
   parameter int REQ_LEAD = 1
) (
   input  logic                 vga_clk,
   input  logic                 sys_rst_n,
   input  logic [3*COLOR_W-1:0] pix_data,
   output logic                 pix_req,
   output logic [CNT_W-1:0]     pix_x,
   output logic [CNT_W-1:0]     pix_y,
   output logic                 hsync,
   output logic                 vsync,
   output logic                 vga_blank_n,
   output logic [COLOR_W-1:0]   vga_r,
   output logic [COLOR_W-1:0]   vga_g,
   output logic [COLOR_W-1:0]   vga_b,
   output logic                 frame_start,
   output logic [7:0]           frame_cnt
);

   localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int H_START = H_SYNC + H_BACK;
   localparam int H_END   = H_START + H_ACTIVE - 1;
   localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
   localparam int V_START = V_SYNC + V_BACK;
   localparam int V_END   = V_START + V_ACTIVE - 1;

   localparam logic [CNT_W-1:0] H_LAST_C    = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_SYNC_C    = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] H_START_C   = CNT_W'(H_START);
   localparam logic [CNT_W-1:0] H_END_C     = CNT_W'(H_END);
   localparam logic [CNT_W-1:0] REQ_FIRST_C = CNT_W'(H_START - REQ_LEAD);
   localparam logic [CNT_W-1:0] REQ_LAST_C  = CNT_W'(H_END - REQ_LEAD);
   localparam logic [CNT_W-1:0] V_LAST_C    = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_SYNC_C    = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] V_START_C   = CNT_W'(V_START);
   localparam logic [CNT_W-1:0] V_END_C     = CNT_W'(V_END);
   localparam logic             HS_ACT      = 1'(HS_POL);
   localparam logic             VS_ACT      = 1'(VS_POL);

   if (REQ_LEAD < 1 || REQ_LEAD > H_START) begin : g_bad_req_lead
      $error("vga_timing_gen_param: REQ_LEAD=%0d outside 1..%0d", REQ_LEAD, H_START);
   end
   if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_bad_cnt_w
      $error("vga_timing_gen_param: CNT_W=%0d too narrow for the raster", CNT_W);
   end

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             in_h_sync;
   logic             in_v_sync;
   logic             h_vis;
   logic             v_vis;
   logic             h_req;
   logic             frame_top;

   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST_C) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   always_comb begin
      in_h_sync = (h_cnt < H_SYNC_C);
      in_v_sync = (v_cnt < V_SYNC_C);
      h_vis     = (h_cnt >= H_START_C) && (h_cnt <= H_END_C);
      v_vis     = (v_cnt >= V_START_C) && (v_cnt <= V_END_C);
      h_req     = (h_cnt >= REQ_FIRST_C) && (h_cnt <= REQ_LAST_C);
      frame_top = (h_cnt == '0) && (v_cnt == '0);
   end

   // Request protocol: pix_req/pix_x/pix_y are a one-cycle strobe with no
   // back-pressure; pix_data must carry that pixel exactly REQ_LEAD clocks later.
   always_ff @(posedge vga_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         hsync       <= ~HS_ACT;
         vsync       <= ~VS_ACT;
         vga_blank_n <= 1'b0;
         pix_req     <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         hsync       <= in_h_sync ? HS_ACT : ~HS_ACT;
         vsync       <= in_v_sync ? VS_ACT : ~VS_ACT;
         vga_blank_n <= h_vis && v_vis;
         pix_req     <= h_req && v_vis;
         pix_x       <= (h_req && v_vis) ? h_cnt - REQ_FIRST_C : '0;
         pix_y       <= (h_req && v_vis) ? v_cnt - V_START_C : '0;
         frame_start <= frame_top;
         if (frame_top) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end

   // Colour passes straight through under the registered blank.
   assign vga_r = vga_blank_n ? pix_data[3*COLOR_W-1 -: COLOR_W] : '0;
   assign vga_g = vga_blank_n ? pix_data[2*COLOR_W-1 -: COLOR_W] : '0;
   assign vga_b = vga_blank_n ? pix_data[COLOR_W-1:0] : '0;

endmodule
